conv_window_fetch: RTL and testbench

- Read-side sequencer between the dual/multi-port feature-map BRAM and the convolution MAC array.
- Drives one BRAM read port per kernel row, collects the 1-cycle-latency read data, and assembles a KSIZE x KSIZE sliding window (stride 1, valid padding) over one IMG_W x IMG_W 8-bit feature map.
- Presents windows to the MAC through a valid/ready handshake with full backpressure.

---
 rtl/conv_window_fetch.sv | 188 ++++++++++++++++++
 tb/tb_conv_window_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_fetch.sv
// Read-side sequencer: drives KSIZE BRAM read ports row by row and assembles
// stride-1 KSIZE x KSIZE windows for the MAC array behind a valid/ready handshake.
module conv_window_fetch #(
    parameter int unsigned ADDR_WIDTH = $clog2((252**2)*2),
    parameter int unsigned RAM_WIDTH  = 8,
    parameter int unsigned IMG_W      = 252,
    parameter int unsigned KSIZE      = 3,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    output logic                                o_busy,
    output logic                                o_done,
    output logic [ADDR_WIDTH*KSIZE-1:0]         o_r_addrs,
    input  logic [RAM_WIDTH*KSIZE-1:0]          i_data,
    output logic [RAM_WIDTH*KSIZE*KSIZE-1:0]    o_window,
    output logic                                o_valid,
    input  logic                                i_ready
);

    localparam int unsigned CW   = $clog2(IMG_W + 1);
    localparam int unsigned COLW = RAM_WIDTH * KSIZE;
    localparam int unsigned WINW = COLW * KSIZE;
    localparam int unsigned AALL = ADDR_WIDTH * KSIZE;
    localparam logic [CW-1:0]         LAST_COL = CW'(IMG_W - 1);
    localparam logic [CW-1:0]         LAST_ROW = CW'(IMG_W - KSIZE);
    localparam logic [CW-1:0]         K_CNT    = CW'(KSIZE);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          col_q, col_d, row_q, row_d, fill_q, fill_d;
    logic [ADDR_WIDTH-1:0]  row_base_q, row_base_d;
    logic [AALL-1:0]        addrs_q, addrs_d;
    logic                   a_vld_q, a_vld_d, a_first_q, a_first_d;
    logic                   d_vld_q, d_vld_d, d_first_q, d_first_d;
    logic [COLW-1:0]        skid_q, skid_d;
    logic                   skid_vld_q, skid_vld_d, skid_first_q, skid_first_d;
    logic [WINW-1:0]        win_q, win_d;
    logic                   valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    logic                   stall, hs, src_vld, src_first, shift;
    logic [COLW-1:0]        src_data;

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_r_addrs = addrs_q;
    assign o_window  = win_q;
    assign o_valid   = valid_q;

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            fill_q       <= '0;
            row_base_q   <= '0;
            addrs_q      <= '0;
            a_vld_q      <= 1'b0;
            a_first_q    <= 1'b0;
            d_vld_q      <= 1'b0;
            d_first_q    <= 1'b0;
            skid_q       <= '0;
            skid_vld_q   <= 1'b0;
            skid_first_q <= 1'b0;
            win_q        <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            fill_q       <= fill_d;
            row_base_q   <= row_base_d;
            addrs_q      <= addrs_d;
            a_vld_q      <= a_vld_d;
            a_first_q    <= a_first_d;
            d_vld_q      <= d_vld_d;
            d_first_q    <= d_first_d;
            skid_q       <= skid_d;
            skid_vld_q   <= skid_vld_d;
            skid_first_q <= skid_first_d;
            win_q        <= win_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next-state, issue, column pipeline and window logic
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        fill_d       = fill_q;
        row_base_d   = row_base_q;
        addrs_d      = addrs_q;
        a_vld_d      = a_vld_q;
        a_first_d    = a_first_q;
        skid_d       = skid_q;
        skid_vld_d   = skid_vld_q;
        skid_first_d = skid_first_q;
        win_d        = win_q;
        valid_d      = valid_q;

        stall     = valid_q && !i_ready;
        hs        = valid_q && i_ready;
        src_vld   = skid_vld_q || d_vld_q;
        src_first = skid_vld_q ? skid_first_q : d_first_q;
        src_data  = skid_vld_q ? skid_q : i_data;
        shift     = src_vld && !stall;

        // A stalled address is simply re-read next cycle, so only the
        // word already on i_data needs the skid slot.
        d_vld_d   = a_vld_q && !stall;
        d_first_d = a_first_q;

        if (stall && d_vld_q) begin
            skid_d       = i_data;
            skid_vld_d   = 1'b1;
            skid_first_d = d_first_q;
        end else if (shift && skid_vld_q) begin
            skid_vld_d   = 1'b0;
        end

        if (shift) begin
            for (int ky = 0; ky < int'(KSIZE); ky++) begin
                for (int kx = 0; kx < int'(KSIZE); kx++) begin
                    if (kx == int'(KSIZE) - 1)
                        win_d[(ky*KSIZE + kx)*RAM_WIDTH +: RAM_WIDTH] =
                            src_data[ky*RAM_WIDTH +: RAM_WIDTH];
                    else
                        win_d[(ky*KSIZE + kx)*RAM_WIDTH +: RAM_WIDTH] =
                            win_q[(ky*KSIZE + kx + 1)*RAM_WIDTH +: RAM_WIDTH];
                end
            end
            fill_d  = src_first ? CW'(1) : fill_q + CW'(1);
            valid_d = (fill_d >= K_CNT);
        end else if (hs) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_FETCH;
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = BASE;
                end
            end
            S_FETCH: begin
                if (!a_vld_q || !stall) begin
                    for (int p = 0; p < int'(KSIZE); p++)
                        addrs_d[p*ADDR_WIDTH +: ADDR_WIDTH] = row_base_q +
                            ADDR_WIDTH'(col_q) + ADDR_WIDTH'(p*IMG_W);
                    a_vld_d   = 1'b1;
                    a_first_d = (col_q == '0);
                    if (col_q == LAST_COL) begin
                        col_d      = '0;
                        row_d      = row_q + CW'(1);
                        row_base_d = row_base_q + ROW_STEP;
                        if (row_q == LAST_ROW)
                            state_d = S_DRAIN;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!stall)
                    a_vld_d = 1'b0;
                if (!a_vld_q && !d_vld_q && !skid_vld_q && (!valid_q || hs))
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Bench for conv_window_fetch: a 5x5 map with mem[a]=a for directed scans and a
// full 252x252 map with random backpressure, checked against window arithmetic.
module tb_conv_window_fetch;

    localparam int unsigned AW = 17, RW = 8, K = 3, SW = 5, BW = 252, BBASE = 63504;
    localparam int unsigned SOUT = SW - K + 1, BOUT = BW - K + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s, start_s, busy_s, done_s, valid_s, ready_s;
    logic [AW*K-1:0]   addr_s;
    logic [RW*K-1:0]   data_s;
    logic [RW*K*K-1:0] win_s;
    logic rst_b, start_b, busy_b, done_b, valid_b, ready_b;
    logic [AW*K-1:0]   addr_b;
    logic [RW*K-1:0]   data_b;
    logic [RW*K*K-1:0] win_b;

    int tests = 0, fails = 0;

    conv_window_fetch #(.ADDR_WIDTH(AW), .RAM_WIDTH(RW), .IMG_W(SW), .KSIZE(K), .BASE_ADDR(0)) dut_s (
        .i_clk(clk), .i_rst(rst_s), .i_start(start_s), .o_busy(busy_s), .o_done(done_s),
        .o_r_addrs(addr_s), .i_data(data_s), .o_window(win_s), .o_valid(valid_s), .i_ready(ready_s));

    conv_window_fetch #(.BASE_ADDR(BBASE)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_start(start_b), .o_busy(busy_b), .o_done(done_b),
        .o_r_addrs(addr_b), .i_data(data_b), .o_window(win_b), .o_valid(valid_b), .i_ready(ready_b));

    function automatic logic [7:0] pix_b(input int unsigned a);
        return 8'(((a * 37) >> 3) ^ a);
    endfunction

    // Feature-map BRAMs, one read port per kernel row, 1-cycle latency
    always @(posedge clk) begin
        for (int p = 0; p < int'(K); p++) begin
            data_s[p*RW +: RW] <= 8'(addr_s[p*AW +: AW]);
            data_b[p*RW +: RW] <= pix_b(32'(addr_b[p*AW +: AW]));
        end
    end

    // Expected window at output position (r,c): slot ky*K+kx holds pixel (r+ky, c+kx)
    function automatic logic [71:0] exp_win(input bit big, input int r, input int c);
        logic [71:0] v;
        int unsigned w, base, a;
        v    = '0;
        w    = big ? BW : SW;
        base = big ? BBASE : 0;
        for (int ky = 0; ky < int'(K); ky++)
            for (int kx = 0; kx < int'(K); kx++) begin
                a = base + (32'(r) + 32'(ky)) * w + 32'(c) + 32'(kx);
                v[(ky*K + kx)*RW +: RW] = big ? pix_b(a) : 8'(a);
            end
        return v;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One scan of the 5x5 map. pat: 0 ready=1, 1 toggle 1,0,0,1,0,1, 2 random.
    task automatic scan_s(input int pat, input bit restart_mid, input bit abort4, input string tag);
        int n, cyc, first_v, done_cnt, done_cyc, last_hs, prev_hs_s, gap, nv, nd;
        bit stalled, fin;
        logic [71:0] held;
        logic [5:0] tg;
        tg = 6'b101001;
        n = 0; cyc = 0; first_v = -1; done_cnt = 0; done_cyc = -1; last_hs = -2;
        prev_hs_s = -1; gap = -1; stalled = 0; fin = 0; held = '0;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        while (!fin) begin
            if (stalled) begin
                check({tag, " hold valid"}, 128'(valid_s), 128'(1));
                check({tag, " hold window"}, 128'(win_s), 128'(held));
            end
            if (done_s) begin
                done_cnt++;
                done_cyc = cyc;
                check({tag, " busy low at done"}, 128'(busy_s), 128'(0));
            end
            if (valid_s && first_v < 0) first_v = cyc;
            case (pat)
                0:       ready_s = 1'b1;
                1:       ready_s = tg[cyc % 6];
                default: ready_s = 1'($urandom_range(0, 1));
            endcase
            stalled = valid_s && !ready_s;
            if (stalled) held = win_s;
            if (valid_s && ready_s) begin
                check({tag, " window"}, 128'(win_s), 128'(exp_win(0, n / int'(SOUT), n % int'(SOUT))));
                if (n == 3 && pat == 0) gap = cyc - prev_hs_s - 1;
                prev_hs_s = cyc;
                n++;
                last_hs = cyc + 1;
            end
            start_s = restart_mid && (cyc == 6);
            @(posedge clk); #1;
            cyc++;
            if (abort4 && n == 4) begin
                rst_s = 1'b1;
                @(posedge clk); #1;
                rst_s = 1'b0;
                check({tag, " rst busy"}, 128'(busy_s), 128'(0));
                check({tag, " rst done"}, 128'(done_s), 128'(0));
                check({tag, " rst valid"}, 128'(valid_s), 128'(0));
                check({tag, " rst window"}, 128'(win_s), 128'(0));
                check({tag, " rst addrs"}, 128'(addr_s), 128'(0));
                nv = 0; nd = 0;
                ready_s = 1'b1;
                repeat (20) begin
                    @(posedge clk); #1;
                    nv += int'(valid_s);
                    nd += int'(done_s);
                end
                check({tag, " no valid after abort"}, 128'(nv), 128'(0));
                check({tag, " no done after abort"}, 128'(nd), 128'(0));
                fin = 1;
            end else if (done_cnt > 0 && cyc > done_cyc + 4) begin
                fin = 1;
            end else if (cyc > 300) begin
                check({tag, " timeout windows"}, 128'(n), 128'(SOUT * SOUT));
                fin = 1;
            end
        end
        start_s = 1'b0;
        if (!abort4) begin
            check({tag, " window count"}, 128'(n), 128'(SOUT * SOUT));
            check({tag, " done count"}, 128'(done_cnt), 128'(1));
            check({tag, " done after last hs"}, 128'(done_cyc), 128'(last_hs));
            if (pat == 0) begin
                check({tag, " first valid latency"}, 128'(first_v), 128'(K + 2));
                check({tag, " row gap"}, 128'(gap), 128'(K - 1));
            end
        end
    endtask

    initial begin
        int n, cyc, done_cnt;
        bit stalled, fin;
        logic [71:0] held;
        logic [AW*K-1:0] first_addrs;

        rst_s = 1'b1; start_s = 1'b0; ready_s = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; ready_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 128'(busy_s), 128'(0));
        check("reset done", 128'(done_s), 128'(0));
        check("reset valid", 128'(valid_s), 128'(0));
        check("reset window", 128'(win_s), 128'(0));
        check("reset addrs", 128'(addr_s), 128'(0));
        check("reset big valid", 128'(valid_b), 128'(0));
        rst_s = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;

        scan_s(0, 0, 0, "simple");
        scan_s(1, 0, 0, "toggle");
        scan_s(0, 0, 1, "abort");
        scan_s(0, 0, 0, "after_abort");
        scan_s(0, 1, 0, "restart_busy");
        scan_s(2, 0, 0, "random_small");

        // Start coinciding with reset must be dropped
        rst_s = 1'b1; start_s = 1'b1;
        @(posedge clk); #1;
        rst_s = 1'b0; start_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("start under reset busy", 128'(busy_s), 128'(0));
        check("start under reset addrs", 128'(addr_s), 128'(0));

        // Full-size map with random backpressure
        first_addrs = {17'(BBASE + 2*BW), 17'(BBASE + BW), 17'(BBASE)};
        n = 0; cyc = 0; done_cnt = 0; stalled = 0; fin = 0; held = '0;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        while (!fin) begin
            if (cyc == 1) check("big first addrs", 128'(addr_b), 128'(first_addrs));
            if (stalled) begin
                check("big hold valid", 128'(valid_b), 128'(1));
                check("big hold window", 128'(win_b), 128'(held));
            end
            if (done_b) done_cnt++;
            ready_b = ($urandom_range(0, 7) != 0);
            stalled = valid_b && !ready_b;
            if (stalled) held = win_b;
            if (valid_b && ready_b) begin
                check("big window", 128'(win_b), 128'(exp_win(1, n / int'(BOUT), n % int'(BOUT))));
                if (n == int'(BOUT * BOUT) - 1)
                    check("big last top-left", 128'(win_b[7:0]), 128'(pix_b(BBASE + 249*BW + 249)));
                n++;
            end
            @(posedge clk); #1;
            cyc++;
            if (done_cnt > 0 || done_b) begin
                if (done_b) done_cnt++;
                fin = 1;
            end else if (cyc > 95000) begin
                check("big timeout windows", 128'(n), 128'(BOUT * BOUT));
                fin = 1;
            end
        end
        check("big window count", 128'(n), 128'(BOUT * BOUT));
        check("big done count", 128'(done_cnt), 128'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
